// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: SDRAM self-test engine. It writes a selectable pattern
// over an address window through the controller write port, reads the window
// back, and reports the mismatch count, the first failing address/data and a
// pass flag.
// Optional feature macro: SDRAM_TESTER_LOOP_EN. When defined, passes repeat
// while start stays high, odd passes use the inverted pattern, and iter_count
// counts completed passes.
module sdram_pattern_tester #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                WORD_COUNT = 1024,
  parameter int                ADDR_STEP  = 1,
  parameter int                ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       iter_count,
  output logic              writeport_wr,
  output logic [ADDR_W-1:0] writeport_addr,
  output logic [DATA_W-1:0] writeport_data,
  input  logic              writeport_ack,
  output logic              readport_rd,
  output logic [ADDR_W-1:0] readport_addr,
  input  logic [DATA_W-1:0] readport_data,
  input  logic              readport_ack
);

  localparam logic [31:0]       LFSR_SEED = 32'hACE10001;
  localparam logic [31:0]       LAST_IDX  = 32'(WORD_COUNT - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [5:0]        WALK_LAST = 6'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_GAP,
    RD_ISSUE,
    RD_GAP,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic              inv_q;
  logic [31:0]       idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       lfsr_q;
  logic [5:0]        walk_q;

  logic [ADDR_W-1:0] nxt_addr;
  logic [31:0]       nxt_lfsr;
  logic [5:0]        nxt_walk;
  logic [DATA_W-1:0] exp_data;
  logic              last_word;

  // Pattern for one word, optionally inverted for odd loop passes.
  function automatic logic [DATA_W-1:0] calc_pattern(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic [31:0]       l,
    input logic [5:0]        w,
    input logic              inv
  );
    logic [DATA_W-1:0] p;
    case (m)
      2'd0:    p = DATA_W'(a);
      2'd1:    p = DATA_W'(1) << w;
      2'd2:    p = l[DATA_W-1:0];
      default: p = ~DATA_W'(a);
    endcase
    return inv ? ~p : p;
  endfunction

  // Next-word generator values and the expected data for the current word.
  always_comb begin
    nxt_addr  = addr_q + STEP;
    nxt_lfsr  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    nxt_walk  = (walk_q == WALK_LAST) ? 6'd0 : walk_q + 6'd1;
    exp_data  = calc_pattern(mode_q, addr_q, lfsr_q, walk_q, inv_q);
    last_word = (idx_q == LAST_IDX);
  end

`ifdef SDRAM_TESTER_LOOP_EN
  logic [15:0] iter_q;
  assign iter_count = iter_q;
`else
  assign iter_count = 16'd0;
`endif

  // Test sequencer: state, word generators, request outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= 2'd0;
      inv_q          <= 1'b0;
      idx_q          <= 32'd0;
      addr_q         <= BASE_ADDR;
      lfsr_q         <= LFSR_SEED;
      walk_q         <= 6'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      writeport_wr   <= 1'b0;
      writeport_addr <= '0;
      writeport_data <= '0;
      readport_rd    <= 1'b0;
      readport_addr  <= '0;
`ifdef SDRAM_TESTER_LOOP_EN
      iter_q         <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q         <= mode;
            inv_q          <= 1'b0;
            idx_q          <= 32'd0;
            addr_q         <= BASE_ADDR;
            lfsr_q         <= LFSR_SEED;
            walk_q         <= 6'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            writeport_wr   <= 1'b1;
            writeport_addr <= BASE_ADDR;
            writeport_data <= calc_pattern(mode, BASE_ADDR, LFSR_SEED, 6'd0, 1'b0);
`ifdef SDRAM_TESTER_LOOP_EN
            iter_q         <= 16'd0;
`endif
            state          <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (writeport_ack) begin
            writeport_wr <= 1'b0;
            state        <= WR_GAP;
          end
        end
        WR_GAP: begin
          if (last_word) begin
            idx_q         <= 32'd0;
            addr_q        <= BASE_ADDR;
            lfsr_q        <= LFSR_SEED;
            walk_q        <= 6'd0;
            readport_rd   <= 1'b1;
            readport_addr <= BASE_ADDR;
            state         <= RD_ISSUE;
          end else begin
            idx_q          <= idx_q + 32'd1;
            addr_q         <= nxt_addr;
            lfsr_q         <= nxt_lfsr;
            walk_q         <= nxt_walk;
            writeport_wr   <= 1'b1;
            writeport_addr <= nxt_addr;
            writeport_data <= calc_pattern(mode_q, nxt_addr, nxt_lfsr, nxt_walk, inv_q);
            state          <= WR_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (readport_ack) begin
            readport_rd <= 1'b0;
            if (readport_data != exp_data) begin
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              if (err_count == '0) begin
                first_err_addr <= addr_q;
                first_err_data <= readport_data;
              end
            end
            state <= RD_GAP;
          end
        end
        RD_GAP: begin
          if (last_word) begin
`ifdef SDRAM_TESTER_LOOP_EN
            if (start) begin
              iter_q         <= iter_q + 16'd1;
              inv_q          <= ~inv_q;
              idx_q          <= 32'd0;
              addr_q         <= BASE_ADDR;
              lfsr_q         <= LFSR_SEED;
              walk_q         <= 6'd0;
              writeport_wr   <= 1'b1;
              writeport_addr <= BASE_ADDR;
              writeport_data <= calc_pattern(mode_q, BASE_ADDR, LFSR_SEED, 6'd0, ~inv_q);
              state          <= WR_ISSUE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0);
              state <= DONE;
            end
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
            state <= DONE;
`endif
          end else begin
            idx_q         <= idx_q + 32'd1;
            addr_q        <= nxt_addr;
            lfsr_q        <= nxt_lfsr;
            walk_q        <= nxt_walk;
            readport_rd   <= 1'b1;
            readport_addr <= nxt_addr;
            state         <= RD_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Testbench for sdram_pattern_tester: two instances (8-word window at 0 with a
// 16-bit error counter, 20-word window at 'h40 with a 2-bit error counter),
// each served by a small memory model with programmable ack latency.
module tb_sdram_pattern_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_start, a_busy, a_done, a_pass, a_wr, a_wr_ack, a_rd, a_rd_ack;
  logic [1:0]  a_mode;
  logic [15:0] a_err, a_fed, a_iter, a_wdata, a_rdata;
  logic [31:0] a_fea, a_waddr, a_raddr;
  logic [15:0] mem_a [0:255];
  int          a_lat = 0, a_wcnt = 0, a_rcnt = 0, a_wr_total = 0, a_rd_total = 0;
  logic        a_corrupt_en = 1'b0;
  logic [31:0] a_corrupt_addr = 32'd0;

  sdram_pattern_tester #(
    .DATA_W(16), .ADDR_W(32), .BASE_ADDR(32'h0), .WORD_COUNT(8), .ADDR_STEP(1), .ERR_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_err_addr(a_fea), .first_err_data(a_fed), .iter_count(a_iter),
    .writeport_wr(a_wr), .writeport_addr(a_waddr), .writeport_data(a_wdata),
    .writeport_ack(a_wr_ack), .readport_rd(a_rd), .readport_addr(a_raddr),
    .readport_data(a_rdata), .readport_ack(a_rd_ack)
  );

  assign a_wr_ack = a_wr && (a_wcnt == a_lat);
  assign a_rd_ack = a_rd && (a_rcnt == a_lat);
  assign a_rdata  = (a_corrupt_en && a_raddr == a_corrupt_addr) ? 16'hFFFF : mem_a[a_raddr[7:0]];

  // Memory model A: acks after a_lat wait cycles and stores acked writes.
  always @(posedge clk) begin
    if (a_wr) begin
      if (a_wr_ack) begin
        mem_a[a_waddr[7:0]] <= a_wdata;
        a_wcnt <= 0;
        a_wr_total <= a_wr_total + 1;
      end else a_wcnt <= a_wcnt + 1;
    end else a_wcnt <= 0;
    if (a_rd) begin
      if (a_rd_ack) begin
        a_rcnt <= 0;
        a_rd_total <= a_rd_total + 1;
      end else a_rcnt <= a_rcnt + 1;
    end else a_rcnt <= 0;
  end

  // ---------------- instance B ----------------
  logic        b_start, b_busy, b_done, b_pass, b_wr, b_wr_ack, b_rd, b_rd_ack;
  logic [1:0]  b_mode;
  logic [1:0]  b_err;
  logic [15:0] b_fed, b_iter, b_wdata, b_rdata;
  logic [31:0] b_fea, b_waddr, b_raddr;
  logic [15:0] mem_b [0:255];
  int          b_lat = 0, b_wcnt = 0, b_rcnt = 0;
  logic        b_corrupt_all = 1'b0;

  sdram_pattern_tester #(
    .DATA_W(16), .ADDR_W(32), .BASE_ADDR(32'h40), .WORD_COUNT(20), .ADDR_STEP(1), .ERR_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_addr(b_fea), .first_err_data(b_fed), .iter_count(b_iter),
    .writeport_wr(b_wr), .writeport_addr(b_waddr), .writeport_data(b_wdata),
    .writeport_ack(b_wr_ack), .readport_rd(b_rd), .readport_addr(b_raddr),
    .readport_data(b_rdata), .readport_ack(b_rd_ack)
  );

  assign b_wr_ack = b_wr && (b_wcnt == b_lat);
  assign b_rd_ack = b_rd && (b_rcnt == b_lat);
  assign b_rdata  = b_corrupt_all ? ~mem_b[b_raddr[7:0]] : mem_b[b_raddr[7:0]];

  // Memory model B: same behaviour, with an option to corrupt every read.
  always @(posedge clk) begin
    if (b_wr) begin
      if (b_wr_ack) begin
        mem_b[b_waddr[7:0]] <= b_wdata;
        b_wcnt <= 0;
      end else b_wcnt <= b_wcnt + 1;
    end else b_wcnt <= 0;
    if (b_rd) begin
      if (b_rd_ack) b_rcnt <= 0;
      else b_rcnt <= b_rcnt + 1;
    end else b_rcnt <= 0;
  end

  // Runs one pass on A; cycles counts edges from the start-sampling edge to the done edge.
  task automatic run_a(input logic [1:0] m, input int lat, input bit disturb,
                       output int cycles, output bit busy0, output bit timeout);
    @(negedge clk);
    a_lat = lat; a_mode = m; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; busy0 = a_busy; cycles = 1; timeout = 1'b0;
    while (!a_done) begin
      if (cycles > 3000) begin timeout = 1'b1; break; end
      if (disturb && cycles == 10) a_mode = 2'd3;
      a_start = (disturb && cycles >= 10 && cycles < 13);
      @(posedge clk); #1;
      cycles++;
    end
    a_start = 1'b0;
  endtask

  task automatic run_b(input logic [1:0] m, input int lat, output bit timeout);
    int n;
    @(negedge clk);
    b_lat = lat; b_mode = m; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; n = 0; timeout = 1'b0;
    while (!b_done) begin
      if (n > 3000) begin timeout = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    checks++; if ({a_busy, a_done, a_pass, a_wr, a_rd} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {a_busy, a_done, a_pass, a_wr, a_rd}); end
    checks++; if (a_err !== 16'd0 || a_iter !== 16'd0) begin errors++; $display("[TB] FAIL reset_counts: got err=%0h iter=%0h expected 0", a_err, a_iter); end
    checks++; if (a_fea !== 32'd0 || a_fed !== 16'd0) begin errors++; $display("[TB] FAIL reset_first_err: got %0h/%0h expected 0/0", a_fea, a_fed); end
    checks++; if (a_waddr !== 32'd0 || a_wdata !== 16'd0 || a_raddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_ports: got %0h/%0h/%0h expected 0", a_waddr, a_wdata, a_raddr); end
    checks++; if (b_err !== 2'd0 || b_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_b: got err=%0h busy=%b expected 0/0", b_err, b_busy); end
  endtask

  task automatic test_address_pattern;
    int cyc, w0, r0; bit b0, to;
    w0 = a_wr_total; r0 = a_rd_total;
    run_a(2'd0, 0, 1'b0, cyc, b0, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL addr_timeout: got timeout expected done"); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("[TB] FAIL addr_busy_rise: got %b expected 1", b0); end
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL addr_cycles: got %0d expected 33", cyc); end
    checks++; if (a_done !== 1'b1 || a_pass !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL addr_status: got done=%b pass=%b busy=%b expected 1/1/0", a_done, a_pass, a_busy); end
    checks++; if (a_err !== 16'd0 || a_iter !== 16'd0) begin errors++; $display("[TB] FAIL addr_counts: got err=%0h iter=%0h expected 0/0", a_err, a_iter); end
    checks++; if (a_wr_total - w0 != 8 || a_rd_total - r0 != 8) begin errors++; $display("[TB] FAIL addr_txn_count: got wr=%0d rd=%0d expected 8/8", a_wr_total - w0, a_rd_total - r0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem_a[i] !== 16'(i)) begin errors++; $display("[TB] FAIL addr_mem%0d: got %0h expected %0h", i, mem_a[i], i); end
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (a_done !== 1'b1) begin errors++; $display("[TB] FAIL done_hold: got %b expected 1", a_done); end
  endtask

  task automatic test_latency;
    int cyc; bit b0, to;
    run_a(2'd0, 2, 1'b0, cyc, b0, to);
    checks++; if (to || a_pass !== 1'b1 || a_err !== 16'd0) begin errors++; $display("[TB] FAIL lat2_pass: got to=%b pass=%b err=%0h expected 0/1/0", to, a_pass, a_err); end
    checks++; if (mem_a[7] !== 16'h0007) begin errors++; $display("[TB] FAIL lat2_mem7: got %0h expected 7", mem_a[7]); end
  endtask

  task automatic test_walking_one;
    bit to;
    run_b(2'd1, 1, to);
    checks++; if (to || b_pass !== 1'b1 || b_err !== 2'd0) begin errors++; $display("[TB] FAIL walk_pass: got to=%b pass=%b err=%0h expected 0/1/0", to, b_pass, b_err); end
    checks++; if (mem_b[8'h40 + 17] !== 16'h0002) begin errors++; $display("[TB] FAIL walk_word17: got %0h expected 0002", mem_b[8'h40 + 17]); end
    checks++; if (mem_b[8'h40] !== 16'h0001) begin errors++; $display("[TB] FAIL walk_word0: got %0h expected 0001", mem_b[8'h40]); end
    checks++; if (mem_b[8'h40 + 15] !== 16'h8000) begin errors++; $display("[TB] FAIL walk_word15: got %0h expected 8000", mem_b[8'h40 + 15]); end
  endtask

  task automatic test_lfsr;
    int cyc; bit b0, to;
    run_a(2'd2, 0, 1'b0, cyc, b0, to);
    checks++; if (to || a_pass !== 1'b1) begin errors++; $display("[TB] FAIL lfsr_pass: got to=%b pass=%b expected 0/1", to, a_pass); end
    checks++; if (mem_a[0] !== 16'h0001 || mem_a[1] !== 16'h0003) begin errors++; $display("[TB] FAIL lfsr_w01: got %0h %0h expected 0001 0003", mem_a[0], mem_a[1]); end
    checks++; if (mem_a[2] !== 16'h0006 || mem_a[3] !== 16'h000C) begin errors++; $display("[TB] FAIL lfsr_w23: got %0h %0h expected 0006 000c", mem_a[2], mem_a[3]); end
  endtask

  task automatic test_inverted;
    int cyc; bit b0, to;
    run_a(2'd3, 0, 1'b0, cyc, b0, to);
    checks++; if (to || a_pass !== 1'b1) begin errors++; $display("[TB] FAIL inv_pass: got to=%b pass=%b expected 0/1", to, a_pass); end
    checks++; if (mem_a[0] !== 16'hFFFF || mem_a[5] !== 16'hFFFA) begin errors++; $display("[TB] FAIL inv_mem: got %0h %0h expected ffff fffa", mem_a[0], mem_a[5]); end
  endtask

  task automatic test_mismatch;
    int n;
    a_corrupt_en = 1'b1; a_corrupt_addr = 32'd5;
    @(negedge clk);
    a_lat = 0; a_mode = 2'd0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; n = 0;
    while (!(a_rd && a_raddr == 32'd5) && n < 500) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 500) begin errors++; $display("[TB] FAIL mis_reach: got timeout expected read of address 5"); end
    checks++; if (a_err !== 16'd0) begin errors++; $display("[TB] FAIL mis_before: got %0h expected 0", a_err); end
    @(posedge clk); #1;
    checks++; if (a_err !== 16'd1) begin errors++; $display("[TB] FAIL mis_latency: got %0h expected 1", a_err); end
    n = 0;
    while (!a_done && n < 500) begin @(posedge clk); #1; n++; end
    checks++; if (a_done !== 1'b1 || a_pass !== 1'b0 || a_err !== 16'd1) begin errors++; $display("[TB] FAIL mis_status: got done=%b pass=%b err=%0h expected 1/0/1", a_done, a_pass, a_err); end
    checks++; if (a_fea !== 32'd5 || a_fed !== 16'hFFFF) begin errors++; $display("[TB] FAIL mis_first: got %0h/%0h expected 5/ffff", a_fea, a_fed); end
    a_corrupt_en = 1'b0;
  endtask

  task automatic test_saturation;
    bit to;
    b_corrupt_all = 1'b1;
    run_b(2'd0, 0, to);
    checks++; if (to || b_err !== 2'd3 || b_pass !== 1'b0) begin errors++; $display("[TB] FAIL sat_count: got to=%b err=%0h pass=%b expected 0/3/0", to, b_err, b_pass); end
    checks++; if (b_fea !== 32'h40 || b_fed !== 16'hFFBF) begin errors++; $display("[TB] FAIL sat_first: got %0h/%0h expected 40/ffbf", b_fea, b_fed); end
    b_corrupt_all = 1'b0;
  endtask

  task automatic test_start_ignored;
    int cyc; bit b0, to;
    run_a(2'd0, 1, 1'b1, cyc, b0, to);
    checks++; if (to || cyc != 49) begin errors++; $display("[TB] FAIL busy_start_cycles: got %0d to=%b expected 49", cyc, to); end
    checks++; if (a_pass !== 1'b1 || mem_a[3] !== 16'h0003) begin errors++; $display("[TB] FAIL busy_mode_change: got pass=%b mem3=%0h expected 1/0003", a_pass, mem_a[3]); end
  endtask

  task automatic test_reset_midtest;
    int cyc; bit b0, to;
    @(negedge clk);
    a_lat = 3; a_mode = 2'd3; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk); #2;
    checks++; if (a_wr !== 1'b1 || a_wdata !== 16'hFFFF) begin errors++; $display("[TB] FAIL rst_pre: got wr=%b data=%0h expected 1/ffff", a_wr, a_wdata); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_wr !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async: got wr=%b busy=%b expected 0/0", a_wr, a_busy); end
    checks++; if (a_wdata !== 16'd0 || a_waddr !== 32'd0 || a_err !== 16'd0 || a_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_values: got data=%0h addr=%0h err=%0h done=%b expected 0", a_wdata, a_waddr, a_err, a_done); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_a(2'd0, 0, 1'b0, cyc, b0, to);
    checks++; if (to || cyc != 33 || a_pass !== 1'b1) begin errors++; $display("[TB] FAIL rst_rerun: got cycles=%0d pass=%b expected 33/1", cyc, a_pass); end
  endtask

`ifdef SDRAM_TESTER_LOOP_EN
  task automatic test_loop;
    int n; bit got; logic [31:0] s_addr; logic [15:0] s_data;
    got = 1'b0; s_addr = '0; s_data = '0;
    @(negedge clk);
    a_lat = 0; a_mode = 2'd0; a_start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (a_iter != 16'd3 && n < 2000) begin
      if (a_iter == 16'd1 && a_wr && a_wr_ack && !got) begin got = 1'b1; s_addr = a_waddr; s_data = a_wdata; end
      @(posedge clk); #1; n++;
    end
    a_start = 1'b0;
    n = 0;
    while (!a_done && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (a_iter !== 16'd3 || a_done !== 1'b1 || a_pass !== 1'b1) begin errors++; $display("[TB] FAIL loop_end: got iter=%0d done=%b pass=%b expected 3/1/1", a_iter, a_done, a_pass); end
    checks++; if (!got || s_data !== ~s_addr[15:0]) begin errors++; $display("[TB] FAIL loop_odd_write: got %0h at %0h expected inverted address", s_data, s_addr); end
    checks++; if (mem_a[2] !== 16'hFFFD) begin errors++; $display("[TB] FAIL loop_final_mem: got %0h expected fffd", mem_a[2]); end
  endtask
`endif

  initial begin
    a_start = 1'b0; a_mode = 2'd0; b_start = 1'b0; b_mode = 2'd0;
    $display("[TB] starting sdram_pattern_tester bench");
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_address_pattern();
    test_latency();
    test_walking_one();
    test_lfsr();
    test_inverted();
    test_mismatch();
    test_saturation();
    test_start_ignored();
    test_reset_midtest();
`ifdef SDRAM_TESTER_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
